mul_div_hilo_unit: RTL and testbench
====================================

Name: mul_div_hilo_unit

Overview:
- Iterative, multi-cycle multiply/divide unit with its own HI/LO register pair. Serves the MULT/MULTU/DIV/DIVU and MFHI/MFLO/MTHI/MTLO instruction group.
- Replaces the combinational ALU multiply/divide and the level-sensitive HI/LO capture with a parametrised start/busy/done handshake.
- The CPU stalls its PC while `busy` is high and reads `hi`/`lo` through the register-write mux.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; must be even and >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- a  input  WIDTH  multiplicand / dividend (RS).
- b  input  WIDTH  multiplier / divisor (RT).
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress; the CPU holds its PC.
- done  output  1  one-cycle pulse when a result is committed or the operation is aborted.
- div_by_zero  output  1  sticky flag; cleared at the next accepted start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Reset mid-operation discards the operation and emits no done.
- States are IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0: latch op and the operand magnitudes. Signed ops convert negatives to two's-complement magnitude and record result signs (product sign = sign(a) XOR sign(b); quotient likewise; remainder sign = sign(a)).
  - At E0: busy<=1, counter<=0, div_by_zero<=0, state<=RUN.
  - Divide with b=0: instead go straight back to IDLE at E0 with div_by_zero<=1 and done<=1 in the next cycle; hi/lo are unchanged and busy never rises.
- RUN: one iteration per edge, counter increments; after WIDTH iterations (edge E_WIDTH) state<=FIX.
  - Multiply: shift-add over the 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first; partial remainder is WIDTH+1 bits.
- FIX (edge E_WIDTH+1): apply sign correction, then commit.
  - Multiply: hi<=product[2W-1:W], lo<=product[W-1:0].
  - Divide: lo<=quotient (truncated toward zero), hi<=remainder.
  - Same edge: busy<=0, done<=1 for exactly one cycle, state<=IDLE.
  - Total latency start->done = WIDTH+1 edges (33 for WIDTH=32).
- Signed overflow (MIN / -1): lo=MIN, hi=0, no flag; the wrap falls out of magnitude arithmetic.
- start while busy is ignored (no queuing). Operands are latched at E0, so later a/b changes have no effect.
- hi_we/lo_we:
  - Honoured only when busy=0; hi/lo update on the next edge.
  - Ignored while busy, including at the FIX commit edge.
  - hi_we and lo_we together write both registers with wdata.
  - start and hi_we/lo_we in the same IDLE cycle: the write is applied at E0 and the operation's result overwrites it at commit.
- hi/lo are stable except on commit or a legal write; they hold their previous values throughout RUN.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: a multiply leaves RUN as soon as the remaining unshifted multiplier magnitude is zero. Latency becomes (index of highest set bit of |b|)+2 edges. |b|=0 takes 1 RUN edge, so done follows after 2 edges. The accumulator is aligned by a final shift in FIX. Divide latency is unchanged.
- Not defined: every multiply takes the fixed WIDTH+1 edges.

Test Plan:
- MULT a=-7 (0xFFFFFFF9), b=6 -> done exactly 33 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFD6; busy high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-17, b=5 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2); DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=5, b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> done one cycle after start, div_by_zero=1, hi=0x11, lo=0x22, busy never high.
- Start MULT, pulse start again and hi_we=1 wdata=0xAB at edge 10 -> second start and the write are ignored; result and latency match the single-op case.
- Reset asserted at edge 15 of a DIV -> hi=lo=0, busy=0, no done pulse; with MULDIV_EARLY_TERM_EN, MULTU a=3, b=4 -> done after 4 edges, lo=12.

Source files
------------

// File: rtl/mul_div_hilo_unit.sv
// mul_div_hilo_unit
// Iterative multiply/divide unit with its own HI/LO register pair.
// MULT/MULTU use shift-add, one multiplier bit per cycle (LSB first).
// DIV/DIVU use restoring division, one quotient bit per cycle (MSB first).
// Signed operations run on magnitudes and fix the signs up in a final cycle.
// Build option: define MULDIV_EARLY_TERM_EN to let a multiply leave RUN as
// soon as the remaining multiplier bits are all zero.
module mul_div_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`ifdef MULDIV_EARLY_TERM_EN
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
`endif

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_main;   // product or quotient must be negated
  logic               r_neg_rem;    // remainder must be negated
  logic [2*WIDTH-1:0] r_acc;        // mul: product; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_opnd;       // mul: |multiplicand|; div: |divisor|
  logic [WIDTH-1:0]   r_mplier;     // unconsumed multiplier bits
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand decode. Note that |MIN| comes out as MIN, which read as unsigned
  // is exactly 2^(WIDTH-1); that is why MIN / -1 wraps back to MIN for free.
  logic             w_is_div;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  assign w_is_div = op[1];
  assign w_a_neg  = ~op[0] & a[WIDTH-1];
  assign w_b_neg  = ~op[0] & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Shift-add step: add at the top, then shift the whole product right.
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH-1:0]   w_mplier_next;
  assign w_addend      = r_mplier[0] ? r_opnd : '0;
  assign w_sum         = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next    = {w_sum, r_acc[WIDTH-1:1]};
  assign w_mplier_next = {1'b0, r_mplier[WIDTH-1:1]};

  // Restoring step: bring in the next dividend bit, try to subtract.
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_trial - {1'b0, r_opnd};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_div_rem  = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_qbit};

  // RUN exit and final product alignment.
  logic               w_run_last;
  logic [2*WIDTH-1:0] w_mul_aligned;
`ifdef MULDIV_EARLY_TERM_EN
  // After k iterations the product sits k places short of its final shift.
  assign w_run_last    = r_is_div ? (r_cnt == LAST_CNT) : (w_mplier_next == '0);
  assign w_mul_aligned = r_acc >> (FULL_CNT - r_cnt);
`else
  assign w_run_last    = (r_cnt == LAST_CNT);
  assign w_mul_aligned = r_acc;
`endif

  // Sign correction applied at commit.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  assign w_prod = r_neg_main ? -w_mul_aligned : w_mul_aligned;
  assign w_quot = r_neg_main ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // Control FSM, datapath iteration and HI/LO update.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_mplier   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // MTHI/MTLO only land while idle; a result committed later wins.
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            if (w_is_div && (b == '0)) begin
              r_dbz  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_is_div   <= w_is_div;
              r_neg_main <= w_a_neg ^ w_b_neg;
              r_neg_rem  <= w_a_neg;
              r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : {WIDTH{1'b0}})};
              r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
              r_mplier   <= w_b_mag;
              r_cnt      <= '0;
              r_busy     <= 1'b1;
              r_dbz      <= 1'b0;
              r_state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_cnt    <= r_cnt + 1'b1;
          r_acc    <= r_is_div ? w_div_next : w_mul_next;
          r_mplier <= w_mplier_next;
          if (w_run_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mul_div_hilo_unit.sv
// Self-checking bench for mul_div_hilo_unit: directed cases plus random
// operations, compared against a plain-arithmetic model of HI/LO/flag/latency.
module tb_mul_div_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  // Architectural model state.
  logic [W-1:0] m_hi  = '0;
  logic [W-1:0] m_lo  = '0;
  logic         m_dbz = 1'b0;

  mul_div_hilo_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result of one operation from plain 64-bit arithmetic, plus the expected
  // number of edges from the start edge to the edge that raises done.
  function automatic void model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                                output logic rdbz, output int lat);
    longint sa, sb, ua, ub, res, q, r, mag;
    sa   = longint'($signed(ma));
    sb   = longint'($signed(mb));
    ua   = longint'({32'b0, ma});
    ub   = longint'({32'b0, mb});
    rhi  = m_hi;
    rlo  = m_lo;
    rdbz = 1'b0;
    lat  = W + 1;
    case (mop)
      2'b00: begin res = sa * sb; {rhi, rlo} = res; end
      2'b01: begin res = ua * ub; {rhi, rlo} = res; end
      default: begin
        if (mb == '0) begin
          rdbz = 1'b1;
          lat  = 0;
        end else begin
          if (mop == 2'b10) begin q = sa / sb; r = sa % sb; end
          else              begin q = ua / ub; r = ua % ub; end
          rlo = q[W-1:0];
          rhi = r[W-1:0];
        end
      end
    endcase
`ifdef MULDIV_EARLY_TERM_EN
    if (!mop[1]) begin
      mag = mop[0] ? ub : ((sb < 0) ? -sb : sb);
      lat = 2;
      for (int i = 0; i < 64; i++) if (mag[i]) lat = i + 2;
    end
`endif
  endfunction

  task automatic mt_write(input logic wh, input logic wl, input logic [W-1:0] d);
    @(negedge clk);
    hi_we = wh; lo_we = wl; wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    check("mt hi", hi, m_hi);
    check("mt lo", lo, m_lo);
  endtask

  // One operation. Optional MTHI/MTLO on the start cycle; optional extra
  // start + HI/LO write driven into edge number 'interfere_at' (0 = none).
  task automatic run_op(input string tag, input logic [1:0] t_op, input logic [W-1:0] t_a,
                        input logic [W-1:0] t_b, input logic wr_hi, input logic wr_lo,
                        input logic [W-1:0] t_wd, input int interfere_at);
    logic [W-1:0] e_hi, e_lo;
    logic         e_dbz, seen, stable_ok;
    int           e_lat, n, busy_n;
    @(negedge clk);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    hi_we = wr_hi; lo_we = wr_lo; wdata = t_wd;
    if (wr_hi) m_hi = t_wd;
    if (wr_lo) m_lo = t_wd;
    model(t_op, t_a, t_b, e_hi, e_lo, e_dbz, e_lat);
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = ~t_a; b = ~t_b;
    n = 0; busy_n = 0; seen = 1'b0; stable_ok = 1'b1;
    while (n <= 100) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (hi !== m_hi || lo !== m_lo) stable_ok = 1'b0;
      if (n + 1 == interfere_at) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAB; op = ~t_op;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    m_hi = e_hi; m_lo = e_lo; m_dbz = e_dbz;
    check({tag, " done seen"}, seen, 1'b1);
    check({tag, " latency"}, n, e_lat);
    check({tag, " busy cycles"}, busy_n, e_dbz ? 0 : e_lat);
    check({tag, " hilo held"}, stable_ok, 1'b1);
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
    check({tag, " dbz"}, div_by_zero, m_dbz);
    check({tag, " busy at done"}, busy, 1'b0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, done, 1'b0);
  endtask

  initial begin
    int           done_cnt;
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;
    int           sel;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset dbz", div_by_zero, 1'b0);
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    @(negedge clk);
    reset = 1'b0;

    mt_write(1'b1, 1'b0, 32'h0000_0011);
    mt_write(1'b0, 1'b1, 32'h0000_0022);
    mt_write(1'b1, 1'b1, 32'h5A5A_3C3C);

    run_op("mult -7*6", 2'b00, 32'hFFFF_FFF9, 32'd6, 1'b0, 1'b0, '0, 0);
    run_op("multu max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 0);
    run_op("div -17/5", 2'b10, 32'hFFFF_FFEF, 32'd5, 1'b0, 1'b0, '0, 0);
    run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, '0, 0);

    mt_write(1'b1, 1'b0, 32'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 1'b0, 1'b0, '0, 0);
    run_op("div 5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, '0, 0);

    run_op("multu 3*4", 2'b01, 32'd3, 32'd4, 1'b0, 1'b0, '0, 0);
    run_op("mult x*0", 2'b00, 32'h1234_5678, 32'd0, 1'b0, 1'b0, '0, 0);
    run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 0);
    run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, '0, 0);
    run_op("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '0, 0);
    run_op("divu small/big", 2'b11, 32'd3, 32'hFFFF_FFF0, 1'b0, 1'b0, '0, 0);

    // Second start plus MTHI/MTLO at edge 10 of a running multiply.
    run_op("mult busy ignore", 2'b00, 32'h1234_5678, 32'hC000_0003, 1'b0, 1'b0, '0, 10);
    // MTHI in the same cycle as start: visible during RUN, then overwritten.
    run_op("multu wr+start", 2'b01, 32'd9, 32'hF000_0009, 1'b1, 1'b0, 32'h55, 0);

    for (int k = 0; k < 24; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      sel  = $urandom_range(0, 7);
      if (sel == 0)      r_b = '0;
      else if (sel == 1) r_b = W'($urandom_range(0, 15));
      else               r_b = $urandom;
      if ($urandom_range(0, 3) == 0) mt_write(1'b1, 1'b1, $urandom);
      run_op("random", r_op, r_a, r_b, 1'($urandom_range(0, 1)), 1'b0, $urandom, 0);
    end

    // Reset in the middle of a divide: everything clears, no done pulse.
    mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'hFFFF_FFEF; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(posedge clk); #1;
    check("mid-op busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    check("mid-op rst hi", hi, m_hi);
    check("mid-op rst lo", lo, m_lo);
    check("mid-op rst busy", busy, 1'b0);
    check("mid-op rst done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("mid-op no done", done_cnt, 0);
    check("mid-op idle busy", busy, 1'b0);

    run_op("divu after rst", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
